// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes; the most-negative value maps onto 2^(WIDTH-1) unchanged.
    logic             op_signed;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign op_signed = ~op[0];
    assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: acc = {partial product high half, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend bits left to consume / quotient bits}.
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_step;
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, mcand_q};
    assign rem_ge   = ~rem_diff[WIDTH];
    assign rem_new  = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_step = {rem_new, acc_q[WIDTH-2:0], rem_ge};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        a_orig_d   = a_orig_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        state_d    = S_RUN;
                        cnt_d      = '0;
                        is_div_d   = op[1];
                        sign_a_d   = op_signed & a[WIDTH-1];
                        sign_b_d   = op_signed & b[WIDTH-1];
                        a_orig_d   = a;
                        div_zero_d = (b == '0);
                        if (op[1]) begin
                            mcand_d = mag_b;
                            acc_d   = {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            mcand_d = mag_a;
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                        end
                    end else if (op[1:0] == 2'b00) begin
                        hi_d = a;
                    end else if (op[1:0] == 2'b01) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = a_orig_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            a_orig_q   <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            a_orig_q   <= a_orig_d;
            is_div_q   <= is_div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8, plus a reference-model sweep at WIDTH=8.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0;
    logic [2:0]  op32 = 3'd0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [31:0] hi32, lo32;
    logic [1:0]  st32;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;
    logic [1:0]  st8;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .dbg_state_o(st32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbg_state_o(st8)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div on the 32-bit unit, optionally poking MTHI mid-run.
    task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit inj);
        int cyc;
        int done_early;
        logic [63:0] e;
        exp_q.push_back({ehi, elo});
        @(negedge clk);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0; a32 = ~a; b32 = ~b;
        cyc = 0;
        done_early = 0;
        while (busy32 && cyc < 100) begin
            if (done32) done_early++;
            if (inj && cyc == 5) begin
                start32 = 1'b1; op32 = 3'b100; a32 = 32'h1234;
            end else begin
                start32 = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start32 = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        check({tag, "_done_in_busy"}, 64'(done_early), 64'd0);
        check({tag, "_done"}, 64'(done32), 64'd1);
        check({tag, "_hi"}, 64'(hi32), 64'(e[63:32]));
        check({tag, "_lo"}, 64'(lo32), 64'(e[31:0]));
        @(negedge clk);
        check({tag, "_done_drop"}, 64'(done32), 64'd0);
    endtask

    task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo);
        int cyc;
        logic [63:0] e;
        exp_q.push_back({48'd0, ehi, elo});
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b;
        cyc = 0;
        while (busy8 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({tag, "_busy_cycles"}, 64'(cyc), 64'd9);
        check({tag, "_done"}, 64'(done8), 64'd1);
        check({tag, "_hi"}, 64'(hi8), 64'(e[15:8]));
        check({tag, "_lo"}, 64'(lo8), 64'(e[7:0]));
    endtask

    function automatic logic [15:0] model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int x, y, p, q, r;
        logic [15:0] res;
        res = '0;
        if (op[1] && b == 8'd0) begin
            res = {a, 8'hFF};
        end else begin
            x = op[0] ? int'(a) : int'($signed(a));
            y = op[0] ? int'(b) : int'($signed(b));
            if (!op[1]) begin
                p = x * y;
                res = p[15:0];
            end else begin
                q = x / y;
                r = x % y;
                res = {r[7:0], q[7:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] pick8();
        logic [7:0] v;
        case ($urandom_range(0, 5))
            0: v = 8'h00;
            1: v = 8'h80;
            2: v = 8'hFF;
            3: v = 8'h01;
            default: v = 8'($urandom_range(0, 255));
        endcase
        return v;
    endfunction

    initial begin
        logic [7:0]  ra, rb;
        logic [2:0]  rop;
        logic [15:0] e8;

        // reset
        repeat (3) @(negedge clk);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_hi32", 64'(hi32), 64'd0);
        check("rst_lo32", 64'(lo32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 32-bit directed vectors
        run32("mult_neg3x7", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run32("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run32("mult_m1xm1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
        run32("div_neg7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run32("divu_8000_3", 3'b011, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA, 1'b0);
        run32("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run32("div_s_by0", 3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
        run32("mthi_busy", 3'b001, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b1);
        run32("divu_by0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b0);

        // MTLO / MTHI / no-op in IDLE
        @(negedge clk);
        start32 = 1'b1; op32 = 3'b101; a32 = 32'h55;
        @(negedge clk);
        start32 = 1'b0;
        check("mtlo_lo", 64'(lo32), 64'h55);
        check("mtlo_hi_keep", 64'(hi32), 64'd100);
        check("mtlo_no_done", 64'(done32), 64'd0);
        check("mtlo_no_busy", 64'(busy32), 64'd0);
        start32 = 1'b1; op32 = 3'b100; a32 = 32'hABCD;
        @(negedge clk);
        start32 = 1'b0;
        check("mthi_hi", 64'(hi32), 64'hABCD);
        start32 = 1'b1; op32 = 3'b110; a32 = 32'h9999;
        @(negedge clk);
        start32 = 1'b0;
        check("nop_busy", 64'(busy32), 64'd0);
        check("nop_hi", 64'(hi32), 64'hABCD);
        check("nop_lo", 64'(lo32), 64'h55);

        // asynchronous reset at RUN iteration 10
        start32 = 1'b1; op32 = 3'b001; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 64'(busy32), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy32), 64'd0);
        check("arst_hi", 64'(hi32), 64'd0);
        check("arst_lo", 64'(lo32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run32("mult_6x7", 3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // 8-bit directed vectors
        run8("w8_mult_neg3x7", 3'b000, 8'hFD, 8'h07, 8'hFF, 8'hEB);
        run8("w8_multu_max", 3'b001, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8("w8_div_neg7_2", 3'b010, 8'hF9, 8'h02, 8'hFF, 8'hFD);
        run8("w8_divu_80_3", 3'b011, 8'h80, 8'h03, 8'h02, 8'h2A);
        run8("w8_div_ovf", 3'b010, 8'h80, 8'hFF, 8'h00, 8'h80);
        run8("w8_divu_by0", 3'b011, 8'd100, 8'h00, 8'd100, 8'hFF);

        // 8-bit sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = pick8();
            rb  = pick8();
            e8  = model8(rop, ra, rb);
            run8($sformatf("w8_rand%0d_op%0d_%0h_%0h", i, rop, ra, rb), rop, ra, rb, e8[15:8], e8[7:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
